ripple_carry_adder: RTL and testbench

RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

---
 rtl/ripple_carry_adder_pkg.sv | 6 +
 rtl/ripple_carry_adder_full_adder.sv | 16 +
 rtl/ripple_carry_adder.sv | 53 +++++
 tb/tb_ripple_carry_adder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package ripple_carry_adder_pkg;

   localparam int ADDER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder: the single cell repeated along the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half_sum;

   assign half_sum = a ^ b;
   assign s        = half_sum ^ cin;
   assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from full_adder cells, with a registered
// sum, carry-out and signed-overflow flag (one cycle latency).
//
// There is no valid/ready handshake: a new operand set is sampled on every
// rising clk, and its result is visible right after that edge.
module ripple_carry_adder
   import ripple_carry_adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cy_in,
   output logic [WIDTH-1:0] sum,
   output logic             cy_Out,
   output logic             ovf
);

   // carry[i] enters bit i; carry[WIDTH] leaves the MSB.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;
   logic             ovf_comb;

   assign carry[0] = cy_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (sum_comb[i]),
         .cout (carry[i+1])
      );
   end

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum    <= '0;
         cy_Out <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         sum    <= sum_comb;
         cy_Out <= carry[WIDTH];
         ovf    <= ovf_comb;
      end
   end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder: the driver queues expected
// {cy_Out, ovf, sum} words, monitors pop and compare after each edge.
module tb_ripple_carry_adder;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         cy_in = 1'b0;
   logic [W-1:0] sum;
   logic         cy_Out;
   logic         ovf;

   logic [W+1:0] exp_q[$];
   logic [W+1:0] last_exp;
   bit           have_last = 1'b0;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   ripple_carry_adder #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .cy_in  (cy_in),
      .sum    (sum),
      .cy_Out (cy_Out),
      .ovf    (ovf)
   );

   // Independent reference: full-width integer add, overflow from sign bits.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
      logic [W:0] r;
      logic       v;
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      return {r[W], v, r[W-1:0]};
   endfunction

   task automatic check(input string name, input logic [W+1:0] got, input logic [W+1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got cy=%b ovf=%b sum=%h, expected cy=%b ovf=%b sum=%h at %0t",
                  name, got[W+1], got[W], got[W-1:0], exp[W+1], exp[W], exp[W-1:0], $time);
      end
   endtask

   task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic [W+1:0] exp);
      @(negedge clk);
      a     = x;
      b     = y;
      cy_in = c;
      exp_q.push_back(exp);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(a, b, cy_in));
   endtask

   // Pipeline monitor: one result per edge while out of reset.
   initial begin
      logic [W+1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pipe", {cy_Out, ovf, sum}, e);
            last_exp  = e;
            have_last = 1'b1;
         end
      end
   end

   // Hold monitor: inputs change on the falling edge, outputs must not.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && have_last) check("hold", {cy_Out, ovf, sum}, last_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with all-ones inputs: outputs stay zero.
      a = 8'hFF; b = 8'hFF; cy_in = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("reset_async", {cy_Out, ovf, sum}, '0);
      repeat (3) begin
         @(negedge clk);
         check("reset_hold", {cy_Out, ovf, sum}, '0);
      end

      // First edge after release registers FF+FF+1.
      release_reset();
      apply(8'hAF, 8'h5A, 1'b0, {1'b1, 1'b0, 8'h09});
      apply(8'h56, 8'h88, 1'b0, {1'b0, 1'b0, 8'hDE});
      apply(8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80});
      apply(8'hFF, 8'h00, 1'b1, {1'b1, 1'b0, 8'h00});
      apply(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
      apply(8'hFF, 8'hFF, 1'b1, {1'b1, 1'b0, 8'hFF});
      apply(8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00});
      apply(8'h80, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h7F});
      apply(8'h3C, 8'h43, 1'b1, {1'b0, 1'b1, 8'h80});

      // Reset mid-stream after loading 0xAF+0x5A.
      apply(8'hAF, 8'h5A, 1'b0, {1'b1, 1'b0, 8'h09});
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      have_last = 1'b0;
      #1 check("reset_mid", {cy_Out, ovf, sum}, '0);
      repeat (2) begin
         @(negedge clk);
         a = 8'h7F; b = 8'h01; cy_in = 1'b0;
         #1 check("reset_mid_hold", {cy_Out, ovf, sum}, '0);
      end
      release_reset();

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] x;
         logic [W-1:0] y;
         logic         c;
         x = W'($urandom_range(0, (1 << W) - 1));
         y = W'($urandom_range(0, (1 << W) - 1));
         c = 1'($urandom_range(0, 1));
         apply(x, y, c, model(x, y, c));
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
